// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bus between an RV64I core and its data-memory responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_read;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_read, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_read, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory serving RV64I loads/stores with byte enables,
// sign/zero extension and fault detection; doublewords take two array accesses.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, RESP} state_t;

  state_t state, next_state;

  logic                  accept;
  logic                  fault;
  logic                  bad_f3;
  logic                  misaligned;
  logic                  out_of_range;

  logic                  store_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [63:0]           wdata_q;
  logic                  dw_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] idx_hi_q;

  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [31:0]           rd_q;
  logic [31:0]           lo_q;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [3:0]            be;
  logic [31:0]           wr_word;

  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [63:0]           rsp_rdata_q, rsp_rdata_d;

  function automatic logic [63:0] load_ext(input logic [2:0] f3, input logic [31:0] word,
                                           input logic [1:0] off);
    logic [31:0] s;
    s = word >> {off, 3'b000};
    case (f3)
      3'b000:  load_ext = {{56{s[7]}}, s[7:0]};
      3'b001:  load_ext = {{48{s[15]}}, s[15:0]};
      3'b010:  load_ext = {{32{s[31]}}, s};
      3'b100:  load_ext = {56'b0, s[7:0]};
      3'b101:  load_ext = {48'b0, s[15:0]};
      3'b110:  load_ext = {32'b0, s};
      default: load_ext = '0;
    endcase
  endfunction

  assign accept   = bus.req_valid && (state == IDLE);
  assign dw_q     = (f3_q[1:0] == 2'b11);
  assign idx_q    = addr_q[ADDR_WIDTH+1:2];
  // Doubleword addresses are 8-byte aligned, so the low word index is even and +1 is just bit 0.
  assign idx_hi_q = {idx_q[ADDR_WIDTH-1:1], 1'b1};

  always_comb begin
    bad_f3 = bus.req_read ? (bus.req_funct3 == 3'b111) : bus.req_funct3[2];
    case (bus.req_funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = |bus.req_addr[1:0];
      default: misaligned = |bus.req_addr[2:0];
    endcase
    out_of_range = |bus.req_addr[63:ADDR_WIDTH+2];
    fault = (bus.req_read == bus.req_write) | bad_f3 | misaligned | out_of_range;
  end

  always_comb begin
    next_state  = state;
    rd_en       = 1'b0;
    rd_idx      = idx_q;
    mem_we      = 1'b0;
    wr_idx      = idx_q;
    be          = '0;
    wr_word     = wdata_q[31:0];
    rsp_error_d = 1'b0;
    rsp_rdata_d = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (fault) begin
            next_state  = RESP;
            rsp_error_d = 1'b1;
          end else begin
            // Low word is read on the accept edge so its data is ready to extend in ACC_LO.
            next_state = ACC_LO;
            rd_en      = bus.req_read;
            rd_idx     = bus.req_addr[ADDR_WIDTH+1:2];
          end
        end
      end
      ACC_LO: begin
        if (dw_q) begin
          next_state = ACC_HI;
          rd_en      = !store_q;
          rd_idx     = idx_hi_q;
        end else begin
          next_state = RESP;
        end
        if (store_q) begin
          mem_we = 1'b1;
          case (f3_q[1:0])
            2'b00: begin
              be      = 4'b0001 << addr_q[1:0];
              wr_word = {4{wdata_q[7:0]}};
            end
            2'b01: begin
              be      = 4'b0011 << addr_q[1:0];
              wr_word = {2{wdata_q[15:0]}};
            end
            default: begin
              be      = '1;
              wr_word = wdata_q[31:0];
            end
          endcase
        end else if (!dw_q) begin
          rsp_rdata_d = load_ext(f3_q, rd_q, addr_q[1:0]);
        end
      end
      ACC_HI: begin
        next_state = RESP;
        if (store_q) begin
          mem_we  = 1'b1;
          wr_idx  = idx_hi_q;
          be      = '1;
          wr_word = wdata_q[63:32];
        end else begin
          rsp_rdata_d = {rd_q, lo_q};
        end
      end
      RESP: next_state = IDLE;
    endcase
    rsp_valid_d = (next_state == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
      store_q     <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state       <= next_state;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (accept) begin
        store_q <= bus.req_write;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr[ADDR_WIDTH+1:0];
        wdata_q <= bus.req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[wr_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
    if (rd_en) rd_q <= mem[rd_idx];
    if (state == ACC_LO) lo_q <= rd_q;
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule
